// File: rtl/scan_pkg.sv
// Shared definitions for the matrix scanner: FSM state encoding and default
// matrix geometry, also used by downstream display/tracking logic.
package scan_pkg;

  localparam int SW_WIRE_CNT_DEF = 16;
  localparam int RD_WIRE_CNT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    SETTLE,
    CONVERT,
    WAIT_ADC,
    STORE,
    ADVANCE
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Down-counter shared by the settle and ADC-timeout intervals. A start pulse
// loads (interval-1); expired is high in the last cycle of the interval.
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] load_val,
  input  logic         start,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expired = run_q && (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row/column matrix scanner: drives one switch wire at a time, samples every
// read wire through an external ADC and writes each sample to a frame buffer.
//
// state    | meaning
// IDLE     | not scanning, all wires released
// BREAK    | one cycle with no row driven before a new row is selected
// SETTLE   | row and column selected, waiting for the line to settle
// CONVERT  | one-cycle ADC start request
// WAIT_ADC | waiting for adc_done or timeout
// STORE    | frame-buffer write of the latched sample
// ADVANCE  | step to next cell, row or frame
module matrix_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SW_WIRE_CNT   = SW_WIRE_CNT_DEF,
  parameter int RD_WIRE_CNT   = RD_WIRE_CNT_DEF,
  parameter int SETTLE_CYCLES = 100,
  parameter int ADC_TIMEOUT   = 1000,
  parameter int ADC_WIDTH     = 12
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  output logic [SW_WIRE_CNT-1:0]                   sw_sel,
  output logic [$clog2(RD_WIRE_CNT)-1:0]           rd_sel,
  output logic                                     adc_start,
  input  logic                                     adc_done,
  input  logic [ADC_WIDTH-1:0]                     adc_data,
  output logic                                     wr_en,
  output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] wr_addr,
  output logic [ADC_WIDTH-1:0]                     wr_data,
  output logic                                     frame_done,
  output logic                                     busy,
  output logic                                     adc_err
);

  localparam int ROW_W  = (SW_WIRE_CNT > 1) ? $clog2(SW_WIRE_CNT) : 1;
  localparam int COL_W  = $clog2(RD_WIRE_CNT);
  localparam int ADDR_W = $clog2(SW_WIRE_CNT * RD_WIRE_CNT);
  localparam int TMR_W  = $clog2(max_int(SETTLE_CYCLES, ADC_TIMEOUT) + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SW_WIRE_CNT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(RD_WIRE_CNT - 1);

  scan_state_e state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ADC_WIDTH-1:0]   data_q, data_d;
  logic [SW_WIRE_CNT-1:0] sw_sel_q, sw_sel_d;
  logic [COL_W-1:0]       rd_sel_q, rd_sel_d;
  logic                   adc_start_q, adc_start_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [ADC_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;
  logic                   adc_err_q, adc_err_d;

  logic             tmr_start;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_expired;

  scan_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_val (tmr_load),
    .start    (tmr_start),
    .expired  (tmr_expired)
  );

  // Next-state and row/column sequencing.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    data_d    = data_q;
    adc_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          row_d   = '0;
          col_d   = '0;
          state_d = BREAK;
        end
      end
      BREAK:   state_d = SETTLE;
      SETTLE:  if (tmr_expired) state_d = CONVERT;
      CONVERT: state_d = WAIT_ADC;
      WAIT_ADC: begin
        if (adc_done) begin
          data_d  = adc_data;
          state_d = STORE;
        end else if (tmr_expired) begin
          data_d    = '1;
          adc_err_d = 1'b1;
          state_d   = STORE;
        end
      end
      STORE:   state_d = ADVANCE;
      ADVANCE: begin
        if (col_q != COL_LAST) begin
          col_d   = col_q + COL_W'(1);
          state_d = SETTLE;
        end else if (row_q != ROW_LAST) begin
          col_d   = '0;
          row_d   = row_q + ROW_W'(1);
          state_d = BREAK;
        end else begin
          row_d   = '0;
          col_d   = '0;
          state_d = enable ? BREAK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer reloads on every state change, so each state sees a fresh count.
  always_comb begin
    tmr_start = (state_d != state_q);
    tmr_load  = (state_d == SETTLE) ? TMR_W'(SETTLE_CYCLES - 1) : TMR_W'(ADC_TIMEOUT - 1);
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    sw_sel_d = '0;
    if ((state_d != IDLE) && (state_d != BREAK)) begin
      sw_sel_d[row_d] = 1'b1;
    end
    rd_sel_d     = col_d;
    adc_start_d  = (state_d == CONVERT);
    wr_en_d      = (state_d == STORE);
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = ADDR_W'(row_d) * ADDR_W'(RD_WIRE_CNT) + ADDR_W'(col_d);
      wr_data_d = data_d;
    end
    frame_done_d = (state_d == ADVANCE) && (state_q == STORE) &&
                   (row_d == ROW_LAST) && (col_d == COL_LAST);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      data_q       <= '0;
      sw_sel_q     <= '0;
      rd_sel_q     <= '0;
      adc_start_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      adc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      data_q       <= data_d;
      sw_sel_q     <= sw_sel_d;
      rd_sel_q     <= rd_sel_d;
      adc_start_q  <= adc_start_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      adc_err_q    <= adc_err_d;
    end
  end

  assign sw_sel     = sw_sel_q;
  assign rd_sel     = rd_sel_q;
  assign adc_start  = adc_start_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign adc_err    = adc_err_q;

endmodule
